instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Encoder counterpart to the CPU's instruction field splitter. Accepts decoded MIPS fields plus a format select over a valid/ready handshake. Packs them into a 32-bit instruction word and writes it big-endian, one byte per cycle, into the byte-wide instruction memory at an auto-incrementing address. Used as the program loader that fills instruction memory before the single-cycle CPU runs.

Parameters:
ADDR_W, 8, byte-address width of instruction memory; MEM_BYTES = 2^ADDR_W.
BASE, 0, first byte address written after reset or clear; must be a multiple of 4.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous; rewinds the write pointer to BASE and zeroes word_count.
in_valid  in  1  field bundle valid.
in_ready  out  1  encoder can accept a bundle this cycle.
fmt  in  2  format: 00 R, 01 I, 10 J, 11 illegal.
op  in  6  opcode, bits [31:26].
rs  in  5  bits [25:21].
rt  in  5  bits [20:16].
rd  in  5  bits [15:11], R-format only.
sa  in  5  bits [10:6], R-format only.
func  in  6  bits [5:0], R-format only.
immediate  in  16  bits [15:0], I-format only.
addr  in  26  bits [25:0], J-format only.
mem_we  out  1  byte write enable to instruction memory.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  8  byte data.
word_out  out  32  last packed word; holds until the next accept.
word_count  out  ADDR_W-1  words written since reset or clear.
full  out  1  no room for another word.
err  out  1  one-cycle pulse when an illegal fmt is accepted.

Behaviour:
- Reset (async, Reset=0):
  - state IDLE, pointer = BASE.
  - mem_we, mem_addr, mem_wdata, word_out, word_count, err = 0.
  - in_ready = 0 while Reset=0.
  - Reset mid-write aborts immediately; the partial word is abandoned.
- Packing, latched on the accept edge (in_valid & in_ready):
  - R: {op,rs,rt,rd,sa,func}.
  - I: {op,rs,rt,immediate}.
  - J: {op,addr}.
  - Fields unused by the selected format are ignored.
- States: IDLE, WR0, WR1, WR2, WR3.
  - in_ready = (state==IDLE) & ~full & ~clear.
- IDLE:
  - On accept with a legal fmt: word_out updates and the next state is WR0.
  - On accept with fmt=11: err=1 for exactly the next cycle; no write, no pointer change; stay IDLE.
- WRk, k=0..3:
  - mem_we=1, mem_addr = ptr+k.
  - mem_wdata = word_out[31-8k : 24-8k] (MSB byte at lowest address).
- Leaving WR3:
  - ptr += 4, word_count += 1, return to IDLE.
  - in_ready may be high in the first IDLE cycle.
- Latency: accept edge to first byte write is 1 cycle. Throughput is 1 word per 5 cycles.
- mem_we = 0 in IDLE; mem_addr/mem_wdata hold their last values there.
- Pointer is ADDR_W+1 bits wide so it never silently wraps.
  - full = (ptr > MEM_BYTES-4).
  - full only deasserts via clear or Reset.
  - With ADDR_W=8 and BASE=0, full asserts after 64 words.
- clear:
  - In IDLE: ptr=BASE, word_count=0, word_out held.
  - In WRk: aborts the word; mem_we=0 from the next cycle, state IDLE, ptr=BASE, word_count=0.
  - clear has priority over an accept in the same cycle; that bundle is not taken.

Decomposition:
- Shared package instr_pkg:
  - FMT_R/FMT_I/FMT_J/FMT_BAD constants.
  - Field bit-position localparams (OP_HI=31 … FUNC_LO=0).
  - Encoder state encoding.
- One natural sub-module, instr_field_pack: combinational fmt+fields → 32-bit word plus illegal flag. The FSM, pointer and byte sequencer stay in the top.

Test Plan:
- R add $1,$2,$3 (op=0, rs=2, rt=3, rd=1, sa=0, func=0x20) → word_out=0x00430820; bytes 00,43,08,20 written at addrs 0..3 on 4 consecutive cycles; word_count=1.
- I addi $1,$2,5 (op=0x08, rs=2, rt=1, imm=0x0005) after the R word → 0x20410005 written at addrs 4..7; J (op=0x02, addr=0x0000010) → 0x08000010 at addrs 8..11.
- fmt=11 with in_valid → err high for one cycle, mem_we stays 0, ptr and word_count unchanged, in_ready remains 1.
- 64 back-to-back legal words → last write at addr 252..255; full=1 and in_ready=0 after the 64th; a 65th valid is not accepted; clear → full=0, next word lands at addr 0.
- Reset asserted during WR2 → all outputs 0 immediately; after release the next word is written at BASE with word_count=1.
- clear asserted in WR1 → mem_we low next cycle, no further bytes; clear and in_valid in the same IDLE cycle → bundle not accepted.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg: shared MIPS format codes, field bit positions and encoder state encoding.
package instr_pkg;

   localparam logic [1:0] FMT_R   = 2'b00;
   localparam logic [1:0] FMT_I   = 2'b01;
   localparam logic [1:0] FMT_J   = 2'b10;
   localparam logic [1:0] FMT_BAD = 2'b11;

   localparam int OP_HI   = 31;
   localparam int OP_LO   = 26;
   localparam int RS_HI   = 25;
   localparam int RS_LO   = 21;
   localparam int RT_HI   = 20;
   localparam int RT_LO   = 16;
   localparam int RD_HI   = 15;
   localparam int RD_LO   = 11;
   localparam int SA_HI   = 10;
   localparam int SA_LO   = 6;
   localparam int FUNC_HI = 5;
   localparam int FUNC_LO = 0;
   localparam int IMM_HI  = 15;
   localparam int IMM_LO  = 0;
   localparam int ADDR_HI = 25;
   localparam int ADDR_LO = 0;

   typedef enum logic [2:0] {ST_IDLE, ST_WR0, ST_WR1, ST_WR2, ST_WR3} enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs decoded MIPS fields into a 32-bit word for the selected format.
module instr_field_pack
   import instr_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  sa,
   input  logic [5:0]  func,
   input  logic [15:0] immediate,
   input  logic [25:0] addr,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word = '0;
      word[OP_HI:OP_LO] = op;
      if (fmt == FMT_J) word[ADDR_HI:ADDR_LO] = addr;
      else begin
         word[RS_HI:RS_LO] = rs;
         word[RT_HI:RT_LO] = rt;
         if (fmt == FMT_I) word[IMM_HI:IMM_LO] = immediate;
         else begin
            word[RD_HI:RD_LO]     = rd;
            word[SA_HI:SA_LO]     = sa;
            word[FUNC_HI:FUNC_LO] = func;
         end
      end
   end

   assign illegal = !(fmt inside {FMT_R, FMT_I, FMT_J});

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts field bundles, packs them and writes each word
// big-endian, one byte per cycle, into byte-wide instruction memory.
module instruction_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int BASE   = 0
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        sa,
   input  logic [5:0]        func,
   input  logic [15:0]       immediate,
   input  logic [25:0]       addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [31:0]       word_out,
   output logic [ADDR_W-2:0] word_count,
   output logic              full,
   output logic              err
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] BASE_P = PTR_W'(BASE);
   localparam logic [PTR_W-1:0] LAST_P = PTR_W'((1 << ADDR_W) - 4);

   enc_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [ADDR_W-2:0] cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [31:0]       packed_word;
   logic              illegal;
   logic              accept;
   logic [1:0]        k;

   instr_field_pack u_pack (
      .fmt       (fmt),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .sa        (sa),
      .func      (func),
      .immediate (immediate),
      .addr      (addr),
      .word      (packed_word),
      .illegal   (illegal)
   );

   assign full     = ptr_q > LAST_P;
   assign in_ready = Reset & (state_q == ST_IDLE) & ~full & ~clear;
   assign accept   = in_valid & in_ready;

   // Byte-lane outputs are registered against the next state so the first byte appears one cycle after accept.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      err_d   = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         ptr_d   = BASE_P;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE) begin
         if (accept && illegal) err_d = 1'b1;
         else if (accept) begin
            word_d  = packed_word;
            state_d = ST_WR0;
         end
      end else if (state_q == ST_WR3) begin
         state_d = ST_IDLE;
         ptr_d   = ptr_q + PTR_W'(4);
         cnt_d   = cnt_q + (ADDR_W-1)'(1);
      end else state_d = enc_state_e'(state_q + 3'd1);
      we_d    = state_d != ST_IDLE;
      k       = 2'(state_d - ST_WR0);
      addr_d  = we_d ? ptr_q[ADDR_W-1:0] + ADDR_W'(k) : addr_q;
      wdata_d = we_d ? word_d[8*(3-int'(k)) +: 8] : wdata_q;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= BASE_P;
         cnt_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_out   = word_q;
   assign word_count = cnt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and random stimulus against a behavioural loader model.
module tb_instruction_encoder;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  fmt = '0;
   logic [5:0]  op = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, sa = '0;
   logic [5:0]  func = '0;
   logic [15:0] immediate = '0;
   logic [25:0] addr = '0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [31:0] word_out;
   logic [6:0]  word_count;
   logic        full;
   logic        err;

   int checks = 0;
   int errors = 0;

   instruction_encoder #(.ADDR_W(8), .BASE(0)) dut (
      .CLK(CLK), .Reset(Reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .func(func),
      .immediate(immediate), .addr(addr), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .word_out(word_out), .word_count(word_count),
      .full(full), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input logic [1:0] f, input logic [5:0] o,
                                        input logic [4:0] s, t, d, a, input logic [5:0] fn,
                                        input logic [15:0] im, input logic [25:0] ad);
      logic [31:0] w;
      w = 32'(o) * 32'h0400_0000;
      if (f == 2'd0) w = w + 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(d) * 32'h800 + 32'(a) * 32'h40 + 32'(fn);
      else if (f == 2'd1) w = w + 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(im);
      else w = w + 32'(ad);
      return w;
   endfunction

   // Behavioural model: phase 0 = idle, phase n = byte n-1 being written.
   int          m_phase = 0, m_ptr = 0, m_cnt = 0;
   logic [31:0] m_word = '0;
   logic        m_we = 1'b0, m_err = 1'b0;
   logic [7:0]  m_addr = '0, m_wdata = '0;
   logic [7:0]  dmem [256];

   function automatic logic m_ready();
      return Reset && m_phase == 0 && m_ptr <= 252 && !clear;
   endfunction

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_phase = 0; m_ptr = 0; m_cnt = 0; m_word = '0;
         m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
      end else begin
         logic acc;
         acc = in_valid && m_ready();
         m_err = 1'b0;
         if (clear) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0;
         end else if (m_phase == 4) begin
            m_phase = 0; m_ptr += 4; m_cnt++;
         end else if (m_phase > 0) m_phase++;
         else if (acc) begin
            if (fmt == 2'd3) m_err = 1'b1;
            else begin
               m_word = pack(fmt, op, rs, rt, rd, sa, func, immediate, addr);
               m_phase = 1;
            end
         end
         m_we = m_phase > 0;
         if (m_we) begin
            m_addr  = 8'((m_ptr + m_phase - 1) % 256);
            m_wdata = 8'(m_word >> (8 * (4 - m_phase)));
         end
      end
   end

   always @(posedge CLK) if (mem_we) dmem[mem_addr] <= mem_wdata;

   always @(negedge CLK) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("word_out", word_out, m_word);
      chk("word_count", word_count, 32'(m_cnt));
      chk("full", full, m_ptr > 252);
      chk("err", err, m_err);
      chk("in_ready", in_ready, m_ready());
   end

   task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s, t, d, a,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
      @(negedge CLK); #1;
      fmt = f; op = o; rs = s; rt = t; rd = d; sa = a; func = fn; immediate = im; addr = ad;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) begin @(negedge CLK); #1; end
      chk("send_ready", in_ready, 1'b1);
      @(posedge CLK); #1 in_valid = 1'b0;
   endtask

   function automatic logic [31:0] dword(input int a);
      return {dmem[a], dmem[a+1], dmem[a+2], dmem[a+3]};
   endfunction

   initial begin
      chk("pack_r", pack(2'd0, 6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0), 32'h00430820);
      chk("pack_i", pack(2'd1, 6'h08, 5'd2, 5'd1, 5'd7, 5'd7, 6'h3F, 16'h0005, 26'h0), 32'h20410005);
      chk("pack_j", pack(2'd2, 6'h02, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h10), 32'h08000010);
      repeat (2) @(negedge CLK);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_word", word_out, 32'h0);
      chk("rst_ready", in_ready, 1'b0);
      #1 Reset = 1'b1;
      // R, I, J words of the loader example
      send(2'd0, 6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20, 16'hBEEF, 26'h0);
      repeat (6) @(negedge CLK);
      chk("r_word", word_out, 32'h00430820);
      chk("r_count", word_count, 32'd1);
      chk("r_mem", dword(0), 32'h00430820);
      send(2'd1, 6'h08, 5'd2, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
      send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10);
      repeat (6) @(negedge CLK);
      chk("i_mem", dword(4), 32'h20410005);
      chk("j_mem", dword(8), 32'h08000010);
      chk("ij_count", word_count, 32'd3);
      // illegal format
      @(negedge CLK); #1 fmt = 2'd3; in_valid = 1'b1;
      @(posedge CLK); #1 in_valid = 1'b0;
      @(negedge CLK);
      chk("bad_err", err, 1'b1);
      chk("bad_ready", in_ready, 1'b1);
      chk("bad_we", mem_we, 1'b0);
      chk("bad_count", word_count, 32'd3);
      @(negedge CLK);
      chk("bad_err_pulse", err, 1'b0);
      // fill memory
      @(negedge CLK); #1 clear = 1'b1;
      @(negedge CLK); #1 clear = 1'b0;
      for (int i = 0; i < 64; i++) send(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0);
      repeat (6) @(negedge CLK);
      chk("fill_full", full, 1'b1);
      chk("fill_ready", in_ready, 1'b0);
      chk("fill_count", word_count, 32'd64);
      chk("fill_last", dword(252), 32'h2001003F);
      #1 in_valid = 1'b1; fmt = 2'd1;
      repeat (10) @(negedge CLK);
      chk("over_count", word_count, 32'd64);
      #1 in_valid = 1'b0; clear = 1'b1;
      @(negedge CLK); #1 clear = 1'b0;
      chk("clr_full", full, 1'b0);
      send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF);
      repeat (6) @(negedge CLK);
      chk("clr_mem0", dword(0), 32'h0BFFFFFF);
      // reset during WR2
      send(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd1, 6'h22, 16'h0, 26'h0);
      @(posedge CLK); @(posedge CLK); #1 Reset = 1'b0;
      #1;
      chk("mid_rst", {mem_we, mem_addr, mem_wdata, err, in_ready, word_count}, 32'h0);
      chk("mid_rst_word", word_out, 32'h0);
      @(negedge CLK); #1 Reset = 1'b1;
      send(2'd1, 6'h08, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
      repeat (6) @(negedge CLK);
      chk("post_rst_count", word_count, 32'd1);
      chk("post_rst_mem", dword(0), 32'h20021234);
      // clear during WR1
      send(2'd0, 6'h00, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0, 26'h0);
      @(posedge CLK); #1 clear = 1'b1;
      @(posedge CLK); #1 clear = 1'b0;
      chk("clr_wr_we", mem_we, 1'b0);
      chk("clr_wr_count", word_count, 32'd0);
      // clear beats accept
      @(negedge CLK); #1 clear = 1'b1; in_valid = 1'b1; fmt = 2'd0;
      @(posedge CLK); #1 clear = 1'b0; in_valid = 1'b0;
      @(negedge CLK);
      chk("clr_acc_we", mem_we, 1'b0);
      // random traffic
      repeat (1500) begin
         @(negedge CLK); #1;
         in_valid = 1'($urandom_range(0, 1));
         fmt = 2'($urandom_range(0, 3));
         op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         sa = 5'($urandom); func = 6'($urandom); immediate = 16'($urandom); addr = 26'($urandom);
         clear = ($urandom_range(0, 99) == 0);
      end
      #1 in_valid = 1'b0; clear = 1'b0;
      repeat (8) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
